// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the pipeline stage registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // Bit positions of the standard side-effect bits inside the control payload
    localparam int unsigned CTRL_WE_REG  = 0;
    localparam int unsigned CTRL_WE_MEM  = 1;
    localparam int unsigned CTRL_IS_LOAD = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_t;

endpackage

`default_nettype wire

// File: rtl/pipe_slot.sv
// ============================================================================
// Module      : pipe_slot
// Description : One valid+data+ctrl register with load, clear and NOP value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_slot #(
    parameter int                DATA_W   = 96,
    parameter int                CTRL_W   = 8,
    parameter logic [DATA_W-1:0] NOP_DATA = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_ld,
    input  logic              i_drop,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    // Dropping a beat only clears valid; the payload keeps its last value
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_valid <= 1'b0;
            r_data  <= NOP_DATA;
            r_ctrl  <= '0;
        end else if (i_ld) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_ctrl  <= i_ctrl;
        end else if (i_drop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ctrl  = r_ctrl;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module      : pipe_stage_reg
// Description : Parametrised valid/ready pipeline stage register with flush
//               and control gating. Define PIPE_SKID_EN for a skid slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 96,
    parameter int                CTRL_W   = 8,
    parameter logic [DATA_W-1:0] NOP_DATA = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_nop
);

    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_main_ld;
    logic              w_main_drop;
    logic [DATA_W-1:0] w_main_ld_data;
    logic [CTRL_W-1:0] w_main_ld_ctrl;
    logic              w_main_valid;
    logic [DATA_W-1:0] w_main_data;
    logic [CTRL_W-1:0] w_main_ctrl;

    assign w_out_xfer = w_main_valid && out_ready;
    assign w_in_xfer  = in_valid && in_ready && !flush;

    pipe_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .NOP_DATA (NOP_DATA)
    ) u_main_slot (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (flush),
        .i_ld    (w_main_ld),
        .i_drop  (w_main_drop),
        .i_data  (w_main_ld_data),
        .i_ctrl  (w_main_ld_ctrl),
        .o_valid (w_main_valid),
        .o_data  (w_main_data),
        .o_ctrl  (w_main_ctrl)
    );

`ifdef PIPE_SKID_EN
    pipe_state_t       r_state;
    pipe_state_t       w_state_nxt;
    logic              r_in_ready;
    logic              w_skid_ld;
    logic              w_skid_drop;
    logic              w_skid_valid;
    logic [DATA_W-1:0] w_skid_data;
    logic [CTRL_W-1:0] w_skid_ctrl;

    pipe_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .NOP_DATA (NOP_DATA)
    ) u_skid_slot (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (flush),
        .i_ld    (w_skid_ld),
        .i_drop  (w_skid_drop),
        .i_data  (in_data),
        .i_ctrl  (in_ctrl),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data),
        .o_ctrl  (w_skid_ctrl)
    );

    // Ready is registered from the next state, so out_ready never reaches it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != SKID);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_ld   = 1'b0;
        w_main_drop = 1'b0;
        w_skid_ld   = 1'b0;
        w_skid_drop = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_nxt = FULL;
                        w_main_ld   = 1'b1;
                    end
                end
                FULL: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_main_ld   = 1'b1;
                    end else if (w_in_xfer) begin
                        w_state_nxt = SKID;
                        w_skid_ld   = 1'b1;
                    end else if (w_out_xfer) begin
                        w_state_nxt = EMPTY;
                        w_main_drop = 1'b1;
                    end
                end
                SKID: begin
                    if (w_out_xfer) begin
                        w_state_nxt = FULL;
                        w_main_ld   = 1'b1;
                        w_skid_drop = 1'b1;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    assign in_ready       = r_in_ready || flush;
    assign w_main_ld_data = w_skid_valid ? w_skid_data : in_data;
    assign w_main_ld_ctrl = w_skid_valid ? w_skid_ctrl : in_ctrl;
`else
    // The main slot's valid bit is the EMPTY/FULL state
    assign in_ready       = flush || !w_main_valid || out_ready;
    assign w_main_ld      = w_in_xfer;
    assign w_main_drop    = w_out_xfer && !w_in_xfer;
    assign w_main_ld_data = in_data;
    assign w_main_ld_ctrl = in_ctrl;
`endif

    assign out_valid = w_main_valid;
    assign out_nop   = !w_main_valid;
    assign out_data  = w_main_data;
    assign out_ctrl  = w_main_valid ? w_main_ctrl : '0;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg against a queue model;
//               follows PIPE_SKID_EN to pick the stage capacity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int                DATA_W   = 96;
    localparam int                CTRL_W   = 8;
    localparam logic [DATA_W-1:0] NOP_DATA = {64'h0, NOP_INSTR};
`ifdef PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif
    localparam int VW = 3 + CTRL_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic              out_nop;

    pipe_stage_reg #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .NOP_DATA (NOP_DATA)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .out_nop   (out_nop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
    } beat_t;

    // Reference model: the stage is a FIFO of capacity CAP
    beat_t             q[$];
    logic [DATA_W-1:0] m_last;
    bit                m_accepted;
    int                errors = 0;
    int                checks = 0;

    function automatic logic m_in_ready();
        if (flush) return 1'b1;
        if (CAP == 2) return q.size() < 2;
        return (q.size() == 0) || out_ready;
    endfunction

    function automatic logic [VW-1:0] expect_vec();
        logic              v;
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
        v = q.size() > 0;
        d = v ? q[0].data : m_last;
        c = v ? q[0].ctrl : '0;
        return {v, !v, m_in_ready(), c, d};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {out_valid, out_nop, in_ready, out_ctrl, out_data};
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic drive(input logic v, input logic [DATA_W-1:0] d,
                         input logic [CTRL_W-1:0] c, input logic ordy,
                         input logic fl, input logic r);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
    endtask

    // Advance the model with the current inputs, then move to the next negedge
    task automatic tick();
        logic rdy;
        m_accepted = 1'b0;
        if (rst || flush) begin
            q.delete();
            m_last = NOP_DATA;
        end else begin
            rdy = m_in_ready();
            if (q.size() > 0 && out_ready) begin
                m_last = q[0].data;
                void'(q.pop_front());
            end
            if (in_valid && rdy) begin
                q.push_back(beat_t'{in_data, in_ctrl});
                m_accepted = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b1, rand_data(), 8'hFF, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++;
        if (out_nop !== 1'b1) begin errors++; $display("FAIL reset_nop: got %b want 1", out_nop); end
        checks++;
        if (out_ctrl !== '0) begin errors++; $display("FAIL reset_ctrl: got %h want 00", out_ctrl); end
        checks++;
        if (out_data !== NOP_DATA) begin errors++; $display("FAIL reset_data: got %h want %h", out_data, NOP_DATA); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++;
        tick();
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 9; i++) begin
            drive(i <= 8, DATA_W'(i), 8'h05, 1'b1, 1'b0, 1'b0);
            #1;
            if (dut_vec() !== expect_vec()) begin
                errors++; $display("FAIL stream_model cyc%0d: got %h want %h", i, dut_vec(), expect_vec());
            end
            checks++;
            if (i > 1 && (out_valid !== 1'b1 || out_data !== DATA_W'(i - 1) || out_ctrl !== 8'h05)) begin
                errors++; $display("FAIL stream_seq cyc%0d: got v=%b d=%h c=%h want v=1 d=%0d c=05",
                                   i, out_valid, out_data, out_ctrl, i - 1);
            end
            checks++;
            tick();
        end
    endtask

    task automatic test_stall();
        logic [DATA_W-1:0] a, b;
        logic [DATA_W-1:0] seen[$];
        bit                b_pend;
        a = rand_data();
        b = rand_data();
        b_pend = 1'b1;
        drive(1'b1, a, 8'h01, 1'b1, 1'b0, 1'b0);
        #1;
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(b_pend, b, 8'h02, 1'b0, 1'b0, 1'b0);
            #1;
            if (dut_vec() !== expect_vec()) begin
                errors++; $display("FAIL stall_model cyc%0d: got %h want %h", k, dut_vec(), expect_vec());
            end
            checks++;
            if (out_valid !== 1'b1 || out_data !== a) begin
                errors++; $display("FAIL stall_hold cyc%0d: got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, a);
            end
            checks++;
            tick();
            if (m_accepted) b_pend = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            drive(b_pend, b, 8'h02, 1'b1, 1'b0, 1'b0);
            #1;
            if (dut_vec() !== expect_vec()) begin
                errors++; $display("FAIL stall_drain cyc%0d: got %h want %h", k, dut_vec(), expect_vec());
            end
            checks++;
            if (out_valid === 1'b1) seen.push_back(out_data);
            tick();
            if (m_accepted) b_pend = 1'b0;
        end
        if (seen.size() < 2 || seen[0] !== a || seen[1] !== b) begin
            errors++; $display("FAIL stall_order: got %0d beats first=%h want A=%h then B=%h",
                               seen.size(), (seen.size() > 0) ? seen[0] : '0, a, b);
        end
        checks++;
    endtask

    task automatic test_flush();
        logic [DATA_W-1:0] c_beat;
        c_beat = rand_data();
        drive(1'b1, rand_data(), 8'h07, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, rand_data(), 8'h07, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, c_beat, 8'hFF, 1'b0, 1'b1, 1'b0);
        #1;
        if (dut_vec() !== expect_vec()) begin
            errors++; $display("FAIL flush_during: got %h want %h", dut_vec(), expect_vec());
        end
        checks++;
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== NOP_DATA || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_after: got v=%b c=%h d=%h rdy=%b want v=0 c=00 d=%h rdy=1",
                               out_valid, out_ctrl, out_data, in_ready, NOP_DATA);
        end
        checks++;
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
            #1;
            if (out_valid !== 1'b0 || out_data === c_beat) begin
                errors++; $display("FAIL flush_no_c cyc%0d: got v=%b d=%h want v=0 and not %h",
                                   k, out_valid, out_data, c_beat);
            end
            checks++;
            tick();
        end
    endtask

    task automatic test_ctrl_gating();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, rand_data(), 8'hFF, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            #1;
            if (out_ctrl !== '0) begin
                errors++; $display("FAIL ctrl_gate cyc%0d: got %h want 00", k, out_ctrl);
            end
            checks++;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] d_beat;
        d_beat = rand_data();
        drive(1'b1, rand_data(), 8'h03, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, d_beat, 8'h06, 1'b1, 1'b0, 1'b0);
        #1;
        if (out_valid !== 1'b0 || out_nop !== 1'b1 || out_ctrl !== '0 ||
            out_data !== NOP_DATA || in_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_values: got v=%b nop=%b c=%h d=%h rdy=%b want 0 1 00 %h 1",
                               out_valid, out_nop, out_ctrl, out_data, in_ready, NOP_DATA);
        end
        checks++;
        tick();
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        #1;
        if (out_valid !== 1'b1 || out_data !== d_beat || out_ctrl !== 8'h06) begin
            errors++; $display("FAIL rstmid_beat_d: got v=%b d=%h c=%h want v=1 d=%h c=06",
                               out_valid, out_data, out_ctrl, d_beat);
        end
        checks++;
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive(($urandom % 4) != 0, rand_data(), CTRL_W'($urandom),
                  ($urandom % 3) != 0, ($urandom % 29) == 0, ($urandom % 97) == 0);
            #1;
            if (dut_vec() !== expect_vec()) begin
                errors++; $display("FAIL random cyc%0d: got %h want %h", k, dut_vec(), expect_vec());
            end
            checks++;
            tick();
        end
    endtask

    initial begin
        m_last = NOP_DATA;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_ctrl_gating();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic, parametrised pipeline stage register that replaces the hand-written per-stage registers between IF/ID/EX/MEM/WB. It carries a data payload and a control payload, with a valid/ready handshake, a flush input that inserts a bubble, and control gating that forces all side-effect bits to zero whenever the stage holds no valid beat. An optional skid slot breaks the combinational ready path so stalls from later stages do not ripple back through the whole pipeline in one cycle.

## Interface
- `DATA_W`, default 96: payload width. Carries PC, immediates, operands and similar fields; holds its value on bubble.
- `CTRL_W`, default 8: control width. Carries we_reg, we_mem, is_load and similar bits; forced to 0 when not valid.
- `NOP_DATA`, default all zeros: value loaded into `out_data` on reset and on flush. The instruction field is set to 32'h00000013 by the instantiating stage.
- `clk`, in, 1: clock. Rising edge.
- `rst`, in, 1: reset. Synchronous, active-high.
- `in_valid`, in, 1: upstream beat present.
- `in_ready`, out, 1: stage accepts a beat this cycle.
- `in_data`, in, `DATA_W`: upstream payload.
- `in_ctrl`, in, `CTRL_W`: upstream control.
- `flush`, in, 1: discard all held beats and the incoming beat.
- `out_valid`, out, 1: beat presented downstream.
- `out_ready`, in, 1: downstream accepts.
- `out_data`, out, `DATA_W`: held payload.
- `out_ctrl`, out, `CTRL_W`: held control, gated by `out_valid`.
- `out_nop`, out, 1: equals `!out_valid`. Compatibility with the existing nop_out consumers.

## Operation
- Transfer in: a beat enters when `in_valid && in_ready`. Transfer out: a beat leaves when `out_valid && out_ready`.
- Main slot:
  - Loads on transfer-in when it is empty or leaving this cycle.
  - Otherwise holds. Stall is implicit through `out_ready=0`.
- Control gating: `out_ctrl = out_valid ? ctrl_reg : 0`, always, including after reset.
- Flush has highest priority after `rst`. On the edge where it is sampled:
  - All slots become empty.
  - `out_data` is set to `NOP_DATA` and `ctrl_reg` to 0.
  - A simultaneous `in_valid` beat is dropped.
  - `in_ready` is 1 during flush, so upstream sees the beat as consumed.
- Simultaneous transfer-in and transfer-out with the stage full: the new beat replaces the leaving beat and the occupancy is unchanged.
- Reset mid-operation behaves the same as flush and also returns the state machine to EMPTY.
- Reset values:
  - `out_valid=0`, `out_nop=1`, `out_ctrl=0`, `out_data=NOP_DATA`.
  - `in_ready=1`.
- State machine, when `PIPE_SKID_EN` is defined:
  - EMPTY → FULL on transfer-in.
  - FULL → EMPTY on transfer-out with no transfer-in.
  - FULL → SKID on transfer-in while `out_ready=0`. The incoming beat goes to the skid slot.
  - SKID → FULL on transfer-out. The skid beat moves to the main slot. `in_ready` is 0 in SKID, so no beat can enter on that edge.
  - Any state → EMPTY on `flush` or `rst`.

## Timing
- Latency: 1 cycle from transfer-in to `out_valid`.
- Throughput: 1 beat per cycle when `out_ready` is held at 1.
- Without skid: `in_ready = !out_valid || out_ready`. This is a combinational path from `out_ready`.
- With skid: `in_ready` is a registered signal equal to `state != SKID`. There is no combinational path from `out_ready` to `in_ready`.
- Ordering: beats are never reordered or duplicated. Beats are lost only through `flush`.
- `out_data` and `out_ctrl` must stay stable while `out_valid && !out_ready`.

## Configuration
- Macro: `PIPE_SKID_EN`.
- Defined: the skid slot (second `DATA_W+CTRL_W` register) and the 3-state machine are instantiated, and `in_ready` is registered.
- Undefined: single slot with two states (EMPTY/FULL) and combinational `in_ready`. The area is the same as the existing stage registers.
- Port list and reset values are identical in both builds.

## Structure
- Shared package `pipe_pkg`:
  - `NOP_INSTR = 32'h00000013`.
  - State enum `pipe_state_t {EMPTY, FULL, SKID}`.
  - Standard control-bit index constants: `CTRL_WE_REG`, `CTRL_WE_MEM`, `CTRL_IS_LOAD`.
- One sub-module, `pipe_slot`: a single valid+data+ctrl register with load, clear and NOP value. It is instantiated once for the main slot, plus once for the skid slot under `PIPE_SKID_EN`.

## Test plan
- Reset, with `rst=1` for 2 cycles and then released:
  - `out_valid=0`, `out_nop=1`, `out_ctrl=0`, `out_data=NOP_DATA`, `in_ready=1`.
  - This holds for both builds.
- Streaming: `out_ready=1` and beats with data 1..8 and ctrl 8'h05 → the same sequence appears on `out_data` one cycle later, with no gaps.
- Stall:
  - Beat A is accepted, then `out_ready=0` for 3 cycles while beat B is offered.
  - `out_data=A` is held stable for those 3 cycles.
  - Without skid, `in_ready=0`. With skid, B is accepted into SKID and then `in_ready=0`.
  - After `out_ready` is raised, output order is A then B.
- Flush while in SKID with `in_valid=1` (beat C):
  - Next cycle: `out_valid=0`, `out_ctrl=0`, `out_data=NOP_DATA`, `in_ready=1`.
  - Beat C never appears on the output.
- Control gating: `in_ctrl=8'hFF` with `in_valid=0` for 4 cycles → `out_ctrl` stays 0 throughout.
- Reset mid-stream: assert `rst` while in FULL with `out_ready=0` → next cycle matches the reset values. The following beat D is accepted and emerges after 1 cycle.
